ebus_diag_master: RTL and testbench
===================================

Name: ebus_diag_master

Overview:
- Front-end side initiator of the EBUS diagnostic-function protocol, the other end of the responders in CRA and similar boards.
- Accepts one command at a time from the console/front-end: a diagnostic function code plus a write flag and data.
- Drives the function code, strobe and EBUS data with fixed setup/strobe/hold timing. For reads, samples the EBUS while the responder drives it.
- Sits between the front-end command path and the shared EBUS.

Parameters:
- SETUP, 2, cycles function code and data are stable before strobe asserts (min 1).
- STROBE, 2, cycles strobe is held asserted (min 1).
- HOLD, 1, cycles function code and data stay stable after strobe deasserts (min 0).
- RDWAIT, 3, cycles after strobe asserts at which read data is sampled (1..STROBE+HOLD).
- TIMEOUT, 16, read timeout in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- cmdValid  in  1  front-end command valid.
- cmdReady  out  1  block idle, command accepted when cmdValid&cmdReady.
- cmdFunc  in  [0:6]  diagnostic function code (e.g. 051, 052 octal).
- cmdWrite  in  1  1=write (master drives EBUS), 0=read.
- cmdData  in  [0:35]  write data.
- diagFunc  out  [0:6]  function code onto EBUS diag lines.
- diagStrobe  out  1  diagnostic function strobe.
- drivingEBUS  out  1  master drives EBUS data.
- ebusOut  out  [0:35]  EBUS data driven by master.
- ebusIn  in  [0:35]  EBUS data from bus.
- ebusDrivenIn  in  1  OR of all responders' drivingEBUS.
- rspValid  out  1  one-cycle pulse, command complete.
- rspData  out  [0:35]  read data (0 for writes), held until next rspValid.
- rspTimeout  out  1  valid with rspValid; read found no responder (optional feature only, else 0).

Behaviour:
- Reset: state IDLE. cmdReady=1. diagFunc=0, diagStrobe=0, drivingEBUS=0, ebusOut=0, rspValid=0, rspData=0, rspTimeout=0, counter=0.
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE: cmdReady=1. On cmdValid, latch func/write/data, load counter=SETUP-1, go to SETUP. cmdReady drops the next cycle.
- SETUP: diagFunc=latched code. If write, drivingEBUS=1 and ebusOut=latched data. When the counter reaches 0, go to STROBE with counter=STROBE-1.
- STROBE: diagStrobe=1, func/data unchanged. At counter 0: go to HOLD (counter=HOLD-1) if HOLD>0, else DONE.
- HOLD: diagStrobe=0, func/data still driven. At counter 0, go to DONE.
- Read sample: a strobe-relative cycle counter starts at 1 on the first STROBE cycle. When it equals RDWAIT, capture ebusIn into the read register. Reads never drive EBUS (drivingEBUS=0 throughout).
- DONE (1 cycle): diagFunc=0, drivingEBUS=0, ebusOut=0. rspValid=1. rspData=captured read data (0 for writes). Next state IDLE.
- Write latency from accept to rspValid: SETUP+STROBE+HOLD+1 cycles. Defaults give 6.
- Commands presented while busy are ignored; the front-end must hold cmdValid until accepted.
- Back-to-back: cmdValid in the cycle after DONE is accepted. Command lines are never driven across commands without the DONE gap.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). No rspValid is produced for the aborted command.
- Master must never drive EBUS while ebusDrivenIn is high. If ebusDrivenIn=1 during a write's SETUP/STROBE/HOLD, the write still completes. This is a bus error flagged by an assertion only; no RTL change.

Optional Feature:
- Macro EBUS_DIAG_TIMEOUT_EN.
- With it: a read's STROBE phase extends until ebusDrivenIn=1, then samples RDWAIT cycles later (the strobe-relative counter restarts on the first driven cycle). If ebusDrivenIn stays 0 for TIMEOUT cycles after strobe asserts, go to HOLD with rspData=0 and rspTimeout=1 at DONE.
- Without it: fixed RDWAIT sampling, rspTimeout tied to 0.

Test Plan:
- Reset mid-STROBE of a write -> diagStrobe, drivingEBUS, diagFunc drop asynchronously. No rspValid. cmdReady=1 after reset release.
- Write, func 051, data 0o123456000000 -> diagFunc=051 for 5 cycles. Strobe high cycles 3-4 after accept. drivingEBUS=1 with ebusOut=data for those 5 cycles. rspValid at cycle 6 with rspData=0.
- Read, func 052, responder model drives ebusIn=0o777000111222 while strobe is high -> drivingEBUS stays 0. rspData=0o777000111222 at rspValid.
- Back-to-back write then read with cmdValid held -> second accepted the cycle after the first rspValid. The two functions never overlap and diagStrobe has a gap of ≥1 cycle.
- cmdValid pulsed while busy -> ignored, exactly one rspValid.
- EBUS_DIAG_TIMEOUT_EN, read with no responder -> rspValid after 16+HOLD+1 strobe-relative cycles, rspTimeout=1, rspData=0. With a responder delayed 5 cycles -> data sampled 3 cycles after ebusDrivenIn rises, rspTimeout=0.

Source files
------------

// File: rtl/ebus_diag_master.sv
// rtl/ebus_diag_master.sv - EBUS diagnostic-function initiator with fixed setup/strobe/hold timing
// Optional read timeout and responder-relative sampling: define EBUS_DIAG_TIMEOUT_EN.
module ebus_diag_master #(
    parameter int SETUP   = 2,
    parameter int STROBE  = 2,
    parameter int HOLD    = 1,
    parameter int RDWAIT  = 3,
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cmdValid,
    output logic        o_cmdReady,
    input  logic [0:6]  i_cmdFunc,
    input  logic        i_cmdWrite,
    input  logic [0:35] i_cmdData,
    output logic [0:6]  o_diagFunc,
    output logic        o_diagStrobe,
    output logic        o_drivingEBUS,
    output logic [0:35] o_ebusOut,
    input  logic [0:35] i_ebusIn,
    input  logic        i_ebusDrivenIn,
    output logic        o_rspValid,
    output logic [0:35] o_rspData,
    output logic        o_rspTimeout
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE} state_t;

    localparam int L_PHASES = SETUP + STROBE + HOLD;
    localparam int L_MAX    = (TIMEOUT > L_PHASES) ? TIMEOUT : L_PHASES;
    localparam int CW       = $clog2(L_MAX + 2);
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t L_SETUP  = cnt_t'(SETUP - 1);
    localparam cnt_t L_STROBE = cnt_t'(STROBE - 1);
    localparam cnt_t L_HOLD   = cnt_t'((HOLD > 0) ? HOLD - 1 : 0);
    localparam cnt_t L_RDWAIT = cnt_t'(RDWAIT);

    state_t      r_state, w_next;
    cnt_t        r_cnt, w_cnt;
    cnt_t        r_rel, w_rel;
    logic [0:6]  r_func;
    logic        r_wr;
    logic [0:35] r_wdata, r_rd, w_rd, r_rsp_data;
    logic        w_drv, w_sample, w_tmo_hit, w_tmo, w_active, w_accept;

`ifdef EBUS_DIAG_TIMEOUT_EN
    localparam cnt_t L_TIMEOUT = cnt_t'(TIMEOUT - 1);
    logic r_seen, r_tmo;
    cnt_t r_to;

    // A read's strobe phase only counts down once a responder has driven the bus.
    assign w_drv     = r_wr | r_seen | i_ebusDrivenIn;
    assign w_rel     = (!r_wr && !r_seen) ? cnt_t'(1) : r_rel;
    assign w_tmo_hit = (r_state == S_STROBE) && !w_drv && (r_to == L_TIMEOUT);
    assign w_tmo     = r_tmo | w_tmo_hit;
`else
    assign w_drv     = 1'b1;
    assign w_rel     = r_rel;
    assign w_tmo_hit = 1'b0;
    assign w_tmo     = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && i_cmdValid;
    assign w_sample = !r_wr && (w_rel == L_RDWAIT) &&
                      (((r_state == S_STROBE) && w_drv) || (r_state == S_HOLD));
    assign w_rd     = w_sample ? i_ebusIn : r_rd;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cnt        = r_cnt;
        w_active     = 1'b0;
        o_cmdReady   = 1'b0;
        o_diagStrobe = 1'b0;
        o_rspValid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_cmdReady = 1'b1;
                if (i_cmdValid) begin
                    w_next = S_SETUP;
                    w_cnt  = L_SETUP;
                end
            end
            S_SETUP: begin
                w_active = 1'b1;
                if (r_cnt == '0) begin
                    w_next = S_STROBE;
                    w_cnt  = L_STROBE;
                end else begin
                    w_cnt = r_cnt - cnt_t'(1);
                end
            end
            S_STROBE: begin
                w_active     = 1'b1;
                o_diagStrobe = 1'b1;
                if (w_tmo_hit || (w_drv && (r_cnt == '0))) begin
                    if (HOLD > 0) begin
                        w_next = S_HOLD;
                        w_cnt  = L_HOLD;
                    end else begin
                        w_next = S_DONE;
                        w_cnt  = '0;
                    end
                end else if (w_drv) begin
                    w_cnt = r_cnt - cnt_t'(1);
                end
            end
            S_HOLD: begin
                w_active = 1'b1;
                if (r_cnt == '0) begin
                    w_next = S_DONE;
                end else begin
                    w_cnt = r_cnt - cnt_t'(1);
                end
            end
            S_DONE: begin
                o_rspValid = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_func     <= '0;
            r_wr       <= 1'b0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_rel      <= '0;
            r_rsp_data <= '0;
`ifdef EBUS_DIAG_TIMEOUT_EN
            r_seen     <= 1'b0;
            r_tmo      <= 1'b0;
            r_to       <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_func  <= i_cmdFunc;
                r_wr    <= i_cmdWrite;
                r_wdata <= i_cmdData;
                r_rd    <= '0;
`ifdef EBUS_DIAG_TIMEOUT_EN
                r_seen  <= 1'b0;
                r_tmo   <= 1'b0;
                r_to    <= '0;
`endif
            end else begin
                r_rd <= w_rd;
            end
            if (r_state == S_SETUP) begin
                r_rel <= cnt_t'(1);
            end else if ((r_state == S_STROBE) || (r_state == S_HOLD)) begin
                r_rel <= w_rel + cnt_t'(1);
            end
            // Sample lands on the same edge as the DONE transition when RDWAIT is the last active cycle.
            if ((r_state != S_DONE) && (w_next == S_DONE)) begin
                r_rsp_data <= (r_wr || w_tmo) ? '0 : w_rd;
            end
`ifdef EBUS_DIAG_TIMEOUT_EN
            if ((r_state == S_STROBE) && !r_wr) begin
                if (w_drv) r_seen <= 1'b1;
                else       r_to   <= r_to + cnt_t'(1);
                if (w_tmo_hit) r_tmo <= 1'b1;
            end
`endif
        end
    end

    assign o_diagFunc    = w_active ? r_func : '0;
    assign o_drivingEBUS = w_active & r_wr;
    assign o_ebusOut     = (w_active && r_wr) ? r_wdata : '0;
    assign o_rspData     = r_rsp_data;
    assign o_rspTimeout  = o_rspValid & w_tmo;

    // Contending with a responder is a bus error; the write still completes.
    assert property (@(posedge i_clk) disable iff (i_reset) !(o_drivingEBUS && i_ebusDrivenIn));

endmodule

// File: tb/tb_ebus_diag_master.sv
// tb/tb_ebus_diag_master.sv - self-checking bench for ebus_diag_master
module tb_ebus_diag_master;
    localparam int P_SETUP   = 2;
    localparam int P_STROBE  = 2;
    localparam int P_HOLD    = 1;
    localparam int P_RDWAIT  = 3;
    localparam int P_TIMEOUT = 16;
    localparam int P_ACT     = P_SETUP + P_STROBE + P_HOLD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_cmdValid = 1'b0;
    logic        o_cmdReady;
    logic [0:6]  i_cmdFunc = '0;
    logic        i_cmdWrite = 1'b0;
    logic [0:35] i_cmdData = '0;
    logic [0:6]  o_diagFunc;
    logic        o_diagStrobe;
    logic        o_drivingEBUS;
    logic [0:35] o_ebusOut;
    logic [0:35] i_ebusIn = '0;
    logic        i_ebusDrivenIn = 1'b0;
    logic        o_rspValid;
    logic [0:35] o_rspData;
    logic        o_rspTimeout;

    always #5 clk = ~clk;

    ebus_diag_master #(
        .SETUP(P_SETUP), .STROBE(P_STROBE), .HOLD(P_HOLD),
        .RDWAIT(P_RDWAIT), .TIMEOUT(P_TIMEOUT)
    ) dut (
        .i_clk(clk), .i_reset(rst),
        .i_cmdValid(i_cmdValid), .o_cmdReady(o_cmdReady),
        .i_cmdFunc(i_cmdFunc), .i_cmdWrite(i_cmdWrite), .i_cmdData(i_cmdData),
        .o_diagFunc(o_diagFunc), .o_diagStrobe(o_diagStrobe),
        .o_drivingEBUS(o_drivingEBUS), .o_ebusOut(o_ebusOut),
        .i_ebusIn(i_ebusIn), .i_ebusDrivenIn(i_ebusDrivenIn),
        .o_rspValid(o_rspValid), .o_rspData(o_rspData), .o_rspTimeout(o_rspTimeout)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [35:0] rnd36();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[35:0];
    endfunction

    task automatic drive(input bit v, input bit w, input logic [6:0] f, input logic [35:0] d,
                         input bit dv, input logic [35:0] e);
        i_cmdValid = v; i_cmdWrite = w; i_cmdFunc = f; i_cmdData = d;
        i_ebusDrivenIn = dv; i_ebusIn = e;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: one command is a timeline of offsets k from its accept cycle.
    bit          m_en = 1'b1;
    bit          m_busy = 1'b0;
    bit          m_wr = 1'b0;
    int          m_t0 = 0;
    int          cyc = 0;
    logic [0:6]  m_func = '0;
    logic [0:35] m_data = '0;
    logic [0:35] m_rd = '0;
    logic [0:35] m_rsp = '0;
    int          ck;
    bit          c_in, c_stb, c_done;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_rsp  = '0;
        end
        ck     = cyc - m_t0;
        c_in   = m_busy && ck >= 1 && ck <= P_ACT;
        c_stb  = m_busy && ck > P_SETUP && ck <= P_SETUP + P_STROBE;
        c_done = m_busy && ck == P_ACT + 1;
        if (m_en) begin
            chk("cmdReady", o_cmdReady, !m_busy);
            chk("diagFunc", o_diagFunc, c_in ? m_func : 7'd0);
            chk("diagStrobe", o_diagStrobe, c_stb);
            chk("drivingEBUS", o_drivingEBUS, c_in && m_wr);
            chk("ebusOut", o_ebusOut, (c_in && m_wr) ? m_data : 36'd0);
            chk("rspValid", o_rspValid, c_done);
            chk("rspData", o_rspData, c_done ? (m_wr ? 36'd0 : m_rd) : m_rsp);
            chk("rspTimeout", o_rspTimeout, 1'b0);
        end
        if (!rst && m_en) begin
            if (m_busy) begin
                if (!m_wr && ck == P_SETUP + P_RDWAIT) m_rd = i_ebusIn;
                if (c_done) begin
                    m_rsp  = m_wr ? 36'd0 : m_rd;
                    m_busy = 1'b0;
                end
            end else if (i_cmdValid) begin
                m_busy = 1'b1;
                m_t0   = cyc;
                m_wr   = i_cmdWrite;
                m_func = i_cmdFunc;
                m_data = i_cmdData;
                m_rd   = '0;
            end
        end
        cyc++;
    end

    int rk;
    int n_rsp;
    bit dv;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_cmdReady", o_cmdReady, 1'b1);
        chk("rst_diagFunc", o_diagFunc, 7'd0);
        chk("rst_strobe", o_diagStrobe, 1'b0);
        chk("rst_driving", o_drivingEBUS, 1'b0);
        chk("rst_ebusOut", o_ebusOut, 36'd0);
        chk("rst_rspValid", o_rspValid, 1'b0);
        chk("rst_rspData", o_rspData, 36'd0);
        next_cyc();
        rst = 1'b0;

        // Read: responder drives from strobe through hold.
        for (int k = 0; k <= 7; k++) begin
            next_cyc();
            drive(k == 0, 1'b0, 7'o52, rnd36(), k >= 3 && k <= 5,
                  (k >= 3 && k <= 5) ? 36'o777000111222 : rnd36());
            @(negedge clk);
            chk("rd_driving", o_drivingEBUS, 1'b0);
            chk("rd_func", o_diagFunc, (k >= 1 && k <= 5) ? 7'o52 : 7'o0);
            chk("rd_rspValid", o_rspValid, k == 6);
            if (k == 6) chk("rd_rspData", o_rspData, 36'o777000111222);
        end

        // Write: fixed 2/2/1 timing, response at cycle 6.
        for (int k = 0; k <= 7; k++) begin
            next_cyc();
            drive(k == 0, 1'b1, 7'o51, 36'o123456000000, 1'b0, rnd36());
            @(negedge clk);
            chk("wr_func", o_diagFunc, (k >= 1 && k <= 5) ? 7'o51 : 7'o0);
            chk("wr_strobe", o_diagStrobe, k == 3 || k == 4);
            chk("wr_driving", o_drivingEBUS, k >= 1 && k <= 5);
            chk("wr_ebusOut", o_ebusOut, (k >= 1 && k <= 5) ? 36'o123456000000 : 36'o0);
            chk("wr_rspValid", o_rspValid, k == 6);
            if (k == 6) chk("wr_rspData", o_rspData, 36'o0);
        end

        // Back-to-back write then read with cmdValid held.
        for (int k = 0; k <= 14; k++) begin
            next_cyc();
            drive(k <= 7, k == 0, (k == 0) ? 7'o51 : 7'o52, 36'o707070707070,
                  k >= 10 && k <= 12, (k == 12) ? 36'o555444333222 : rnd36());
            @(negedge clk);
            chk("b2b_strobe", o_diagStrobe, k == 3 || k == 4 || k == 10 || k == 11);
            if (k == 6) chk("b2b_rsp1", o_rspValid, 1'b1);
            if (k == 7) begin
                chk("b2b_gap_ready", o_cmdReady, 1'b1);
                chk("b2b_gap_func", o_diagFunc, 7'o0);
            end
            if (k == 8) chk("b2b_func2", o_diagFunc, 7'o52);
            if (k == 13) begin
                chk("b2b_rsp2", o_rspValid, 1'b1);
                chk("b2b_rspData", o_rspData, 36'o555444333222);
            end
        end

        // cmdValid pulsed while busy is ignored.
        n_rsp = 0;
        for (int k = 0; k <= 10; k++) begin
            next_cyc();
            drive(k == 0 || k == 2, k == 0, (k == 0) ? 7'o51 : 7'o17, rnd36(), 1'b0, rnd36());
            @(negedge clk);
            if (o_rspValid) n_rsp++;
            if (k == 3) chk("busy_func", o_diagFunc, 7'o51);
            if (k == 6) chk("busy_rspData", o_rspData, 36'o0);
        end
        chk("busy_one_rsp", n_rsp, 1);

        // Reset mid-strobe of a write.
        for (int k = 0; k <= 3; k++) begin
            next_cyc();
            drive(k == 0, 1'b1, 7'o33, 36'o111111111111, 1'b0, rnd36());
        end
        chk("pre_rst_strobe", o_diagStrobe, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_strobe", o_diagStrobe, 1'b0);
        chk("async_rst_driving", o_drivingEBUS, 1'b0);
        chk("async_rst_func", o_diagFunc, 7'o0);
        repeat (2) next_cyc();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            next_cyc();
            @(negedge clk);
            chk("post_rst_rspValid", o_rspValid, 1'b0);
            chk("post_rst_ready", o_cmdReady, 1'b1);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            next_cyc();
            rk = cyc - m_t0;
            if (m_busy) dv = m_wr ? 1'b0 : (rk > P_SETUP);
            else        dv = 1'($urandom % 2);
            drive(i < 1490 && ($urandom % 2 == 0), 1'($urandom % 2), 7'($urandom), rnd36(),
                  dv, rnd36());
        end
        repeat (4) next_cyc();

`ifdef EBUS_DIAG_TIMEOUT_EN
        m_en = 1'b0;
        for (int k = 0; k <= 21; k++) begin
            next_cyc();
            drive(k == 0, 1'b0, 7'o52, 36'o0, 1'b0, rnd36());
            @(negedge clk);
            chk("to_strobe", o_diagStrobe, k >= 3 && k <= 18);
            chk("to_rspValid", o_rspValid, k == 20);
            chk("to_rspTimeout", o_rspTimeout, k == 20);
            if (k == 20) chk("to_rspData", o_rspData, 36'o0);
        end
        for (int k = 0; k <= 12; k++) begin
            next_cyc();
            drive(k == 0, 1'b0, 7'o52, 36'o0, k >= 8 && k <= 10,
                  (k == 10) ? 36'o123123123123 : rnd36());
            @(negedge clk);
            chk("dly_strobe", o_diagStrobe, k >= 3 && k <= 9);
            chk("dly_rspValid", o_rspValid, k == 11);
            chk("dly_rspTimeout", o_rspTimeout, 1'b0);
            if (k == 11) chk("dly_rspData", o_rspData, 36'o123123123123);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
